// File: rtl/spi_xfer_pkg.sv
// ---------------------------------------------------------------------------
// spi_xfer_pkg
//   Shared types for the SPI transaction arbiter: the controller state
//   encoding, the read/write flag values and the latched request record.
// ---------------------------------------------------------------------------
package spi_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_CMD_WAIT  = 3'd2,
        ST_DATA      = 3'd3,
        ST_DATA_WAIT = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } req_t;

endpackage

// File: rtl/spi_xfer_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant. When both requests are present the pointer
//   decides; otherwise the single requester wins. The pointer moves to the
//   requester that was not served whenever update pulses.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (pointer favours 0)
//     req[1:0]   request vector
//     update     advance the pointer after a transaction completes
//     served     index of the requester that was just served
//     gnt_valid  any request present
//     gnt_idx    index of the winning requester
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // ptr_q names the requester favoured on a tie.
    logic ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (update) begin
            ptr_q <= ~served;
        end
    end

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req == 2'b11) ? ptr_q : req[1];
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// ---------------------------------------------------------------------------
// spi_xfer_arbiter
//   Transaction controller in front of SPI_Master. Two requesters issue
//   register reads/writes; each accepted request becomes a command byte
//   {rw, addr} followed by one data byte written or read. The SPI clock
//   divider is sampled at grant and held for the whole transaction.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     cfg_sclk_div             requested divider, sampled at grant only
//     reqN_valid/ready/rw/addr/wdata   request channel N (N=0,1)
//     rspN_valid/rdata/err     completion channel N
//     busy                     transaction in flight (non-IDLE)
//     sclk_divider, wr_en, rd_en, tx_wr_data   to SPI_Master
//     wr_finish, rd_finish, rx_rd_data         from SPI_Master
//     state_dbg                current controller state
//
//   Handshake: reqN_valid is held by the requester until reqN_ready pulses.
//   reqN_ready is combinational and only asserts in IDLE for the arbitration
//   winner, so the accept is the single cycle where valid and ready are both
//   high. rspN_valid is a one-cycle pulse with no back-pressure.
// ---------------------------------------------------------------------------
module spi_xfer_arbiter
    import spi_xfer_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] DIV_RESET      = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg_sclk_div,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_rw,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_rdata,
    output logic       rsp0_err,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_rw,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_rdata,
    output logic       rsp1_err,
    output logic       busy,
    output logic [7:0] sclk_divider,
    output logic       wr_en,
    output logic       rd_en,
    output logic [7:0] tx_wr_data,
    input  logic       wr_finish,
    input  logic       rd_finish,
    input  logic [7:0] rx_rd_data,
    output logic [2:0] state_dbg
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    req_t             cur_q, sel_req;
    logic             gnt_q;
    logic [7:0]       rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic arb_valid, arb_idx, accept, timeout_hit, data_done, in_resp;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({req1_valid, req0_valid}),
        .update    (in_resp),
        .served    (gnt_q),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    assign sel_req = arb_idx ? {req1_rw, req1_addr, req1_wdata}
                             : {req0_rw, req0_addr, req0_wdata};

    // Gated by rst so no accept is signalled on a cycle that reset discards.
    assign accept     = (state_q == ST_IDLE) && arb_valid && !rst;
    assign req0_ready = accept && !arb_idx;
    assign req1_ready = accept && arb_idx;

    // The current WAIT cycle is the TIMEOUT_CYCLES-th one when the counter
    // (cleared on entry) shows TIMEOUT_CYCLES-1.
    assign timeout_hit = (cnt_q == CNT_LAST);
    assign data_done   = (cur_q.rw == RW_READ) ? rd_finish : wr_finish;

    assign in_resp    = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rsp0_valid = in_resp && !gnt_q;
    assign rsp1_valid = in_resp && gnt_q;
    assign rsp0_rdata = rsp0_valid ? rdata_q : 8'h00;
    assign rsp1_rdata = rsp1_valid ? rdata_q : 8'h00;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;
    assign state_dbg  = state_q;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE:      if (accept) state_d = ST_CMD;
            ST_CMD: begin
                wr_en   = 1'b1;
                state_d = ST_CMD_WAIT;
            end
            ST_CMD_WAIT:  if (wr_finish || timeout_hit) state_d = wr_finish ? ST_DATA : ST_RESP;
            ST_DATA: begin
                wr_en   = (cur_q.rw == RW_WRITE);
                rd_en   = (cur_q.rw == RW_READ);
                state_d = ST_DATA_WAIT;
            end
            ST_DATA_WAIT: if (data_done || timeout_hit) state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            gnt_q        <= 1'b0;
            rdata_q      <= 8'h00;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            tx_wr_data   <= 8'h00;
            sclk_divider <= DIV_RESET;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (accept) begin
                    cur_q        <= sel_req;
                    gnt_q        <= arb_idx;
                    sclk_divider <= cfg_sclk_div;
                    tx_wr_data   <= {sel_req.rw, sel_req.addr};
                    rdata_q      <= 8'h00;
                    err_q        <= 1'b0;
                end
                ST_CMD, ST_DATA: cnt_q <= '0;
                ST_CMD_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Write data is staged here so it is on the bus for the
                    // DATA strobe; reads keep the command byte on the bus.
                    if (wr_finish) begin
                        if (cur_q.rw == RW_WRITE) tx_wr_data <= cur_q.wdata;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                ST_DATA_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (data_done) begin
                        if (cur_q.rw == RW_READ) rdata_q <= rx_rd_data;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
module tb_spi_xfer_arbiter;
  import spi_xfer_pkg::*;

  localparam int TO = 16;

  logic       clk, rst;
  logic [7:0] cfg_sclk_div;
  logic       req0_valid, req0_ready, req0_rw;
  logic [6:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       rsp0_valid, rsp0_err;
  logic [7:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_rw;
  logic [6:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp1_valid, rsp1_err;
  logic [7:0] rsp1_rdata;
  logic       busy, wr_en, rd_en, wr_finish, rd_finish;
  logic [7:0] sclk_divider, tx_wr_data, rx_rd_data;
  logic [2:0] state_dbg;

  spi_xfer_arbiter #(.TIMEOUT_CYCLES(TO), .DIV_RESET(8'd4)) dut (
    .clk(clk), .rst(rst), .cfg_sclk_div(cfg_sclk_div),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .busy(busy), .sclk_divider(sclk_divider), .wr_en(wr_en), .rd_en(rd_en),
    .tx_wr_data(tx_wr_data), .wr_finish(wr_finish), .rd_finish(rd_finish),
    .rx_rd_data(rx_rd_data), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached got=running required=finished");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Read data the SPI slave model returns for a register address.
  function automatic logic [7:0] rx_of(input logic [6:0] a);
    return 8'h5F ^ {1'b0, a};
  endfunction

  logic mute_wr = 1'b0, mute_rd = 1'b0, rand_lat = 1'b0, mon_en = 1'b0;
  int   lat_cur = 0;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- SPI_Master responder ----------------
  initial begin
    int lat;
    wr_finish = 1'b0; rd_finish = 1'b0; rx_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (wr_en && !rst && !mute_wr) begin
        lat = rand_lat ? int'($urandom_range(0, 3)) : lat_cur;
        repeat (lat + 1) @(posedge clk);
        #1 wr_finish = 1'b1;
        @(posedge clk); #1 wr_finish = 1'b0;
      end else if (rd_en && !rst && !mute_rd) begin
        lat = rand_lat ? int'($urandom_range(0, 3)) : lat_cur;
        repeat (lat + 1) @(posedge clk);
        #1 rd_finish = 1'b1; rx_rd_data = rx_of(tx_wr_data[6:0]);
        @(posedge clk); #1 rd_finish = 1'b0; rx_rd_data = 8'hEE;
      end
    end
  end

  // ---------------- scoreboard (transaction-level model) ----------------
  logic [8:0]  exp_q[$];   // {is_read, byte} per expected strobe
  logic [10:0] rsp_q[$];   // {is_read, idx, rdata, err}
  int          gnt_log[$];
  int          last_srv = 1;
  logic [7:0]  m_div;
  int          m_e;
  logic        m_rw;
  logic [6:0]  m_a;
  logic [7:0]  m_wd;
  logic [8:0]  m_s;
  logic [10:0] m_r;
  logic [10:0] m_act, m_exp;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (req0_ready || req1_ready) begin
        m_e = (req0_valid && req1_valid) ? 1 - last_srv : (req1_valid ? 1 : 0);
        check("grant", 32'({req1_ready, req0_ready}), (m_e == 1) ? 32'h2 : 32'h1);
        gnt_log.push_back(req1_ready ? 1 : 0);
        m_rw = m_e[0] ? req1_rw   : req0_rw;
        m_a  = m_e[0] ? req1_addr : req0_addr;
        m_wd = m_e[0] ? req1_wdata : req0_wdata;
        exp_q.push_back({1'b0, m_rw, m_a});
        exp_q.push_back(m_rw ? 9'h100 : {1'b0, m_wd});
        rsp_q.push_back({m_rw, m_e[0], m_rw ? rx_of(m_a) : 8'h00, 1'b0});
        m_div = cfg_sclk_div;
        last_srv = m_e;
      end
      if (wr_en || rd_en) begin
        if (exp_q.size() == 0) check("strobe_unexpected", 32'd1, 32'd0);
        else begin
          m_s = exp_q.pop_front();
          check("strobe", 32'({rd_en, wr_en, rd_en ? 8'h00 : tx_wr_data}),
                32'({m_s[8], ~m_s[8], m_s[7:0]}));
          check("div_pinned", 32'(sclk_divider), 32'(m_div));
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          m_r   = rsp_q.pop_front();
          m_act = {rsp1_valid, rsp0_valid, rsp0_rdata | rsp1_rdata, rsp0_err | rsp1_err};
          m_exp = {m_r[9], ~m_r[9], m_r[8:1], m_r[0]};
          if (!m_r[10]) begin m_act[8:1] = 8'h00; m_exp[8:1] = 8'h00; end
          check("response", 32'(m_act), 32'(m_exp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  req_t src0_q[$], src1_q[$];

  task automatic run_queues(input int gap_pct, input bit rand_cfg, input int budget);
    int cyc; logic a0, a1;
    cyc = 0;
    while (cyc < budget && (src0_q.size() + src1_q.size() + rsp_q.size() > 0 || busy)) begin
      @(negedge clk);
      a0 = req0_ready; a1 = req1_ready;
      @(posedge clk); #1;
      if (a0) begin void'(src0_q.pop_front()); req0_valid = 1'b0; end
      if (a1) begin void'(src1_q.pop_front()); req1_valid = 1'b0; end
      if (!req0_valid && src0_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
        req0_valid = 1'b1; req0_rw = src0_q[0].rw; req0_addr = src0_q[0].addr; req0_wdata = src0_q[0].wdata;
      end
      if (!req1_valid && src1_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
        req1_valid = 1'b1; req1_rw = src1_q[0].rw; req1_addr = src1_q[0].addr; req1_wdata = src1_q[0].wdata;
      end
      if (rand_cfg && $urandom_range(0, 9) == 0) cfg_sclk_div = 8'($urandom);
      cyc++;
    end
    check("src_drained", 32'(src0_q.size() + src1_q.size()), 32'd0);
    check("rsp_drained", 32'(rsp_q.size()), 32'd0);
    check("strobe_drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.rw = 1'($urandom_range(0, 1)); r.addr = 7'($urandom_range(0, 127)); r.wdata = 8'($urandom);
    return r;
  endfunction

  // One transaction on requester idx; reports what the SPI side and the
  // response channel showed.
  task automatic run_xfer(input int idx, input logic rw, input logic [6:0] addr,
                          input logic [7:0] wdata, input logic [7:0] div_in, input logic [7:0] div_mid,
                          output int lat_obs, output int n_str, output logic [8:0] s0, output logic [8:0] s1,
                          output logic [10:0] rsp, output logic [7:0] div_s, output logic [7:0] div_r,
                          output logic busy_r);
    int cyc, acc, rc;
    @(posedge clk); #1;
    cfg_sclk_div = div_in;
    if (idx == 0) begin req0_valid = 1'b1; req0_rw = rw; req0_addr = addr; req0_wdata = wdata; end
    else          begin req1_valid = 1'b1; req1_rw = rw; req1_addr = addr; req1_wdata = wdata; end
    cyc = 0; acc = -1; rc = -1; n_str = 0; s0 = '0; s1 = '0; rsp = '0; div_s = '0; div_r = '0; busy_r = 1'b0;
    while (rc < 0 && cyc < 300) begin
      @(negedge clk);
      if (acc < 0 && ((idx == 0) ? req0_ready : req1_ready)) acc = cyc;
      if (wr_en || rd_en) begin
        n_str++;
        if (n_str == 1) begin s0 = {rd_en, rd_en ? 8'h00 : tx_wr_data}; div_s = sclk_divider; end
        else if (n_str == 2) s1 = {rd_en, rd_en ? 8'h00 : tx_wr_data};
      end
      if (rsp0_valid || rsp1_valid) begin
        rc = cyc;
        rsp = {rsp1_valid, rsp0_valid, rsp0_rdata | rsp1_rdata, rsp0_err | rsp1_err};
        div_r = sclk_divider; busy_r = busy;
      end
      @(posedge clk); #1;
      if (acc == cyc) begin req0_valid = 1'b0; req1_valid = 1'b0; cfg_sclk_div = div_mid; end
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat_obs = (rc >= 0 && acc >= 0) ? rc - acc : -1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int idx; logic rw; logic [6:0] addr; logic [7:0] wdata;
    logic [7:0] div_in; logic [7:0] div_mid; int lat;
    logic [8:0] e_s0; logic [8:0] e_s1; logic [7:0] e_rdata; logic [7:0] e_div; int e_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check_xfer(input string tag, input vec_t v, input int lat_obs, input int n_str,
                            input logic [8:0] s0, input logic [8:0] s1, input logic [10:0] rsp,
                            input logic [7:0] div_s, input logic [7:0] div_r, input logic busy_r);
    logic [10:0] er, ar;
    er = {(v.idx == 1), (v.idx == 0), v.e_rdata, 1'b0};
    ar = rsp;
    if (!v.rw) begin er[8:1] = 8'h00; ar[8:1] = 8'h00; end
    check({tag, "_latency"}, 32'(lat_obs), 32'(v.e_lat));
    check({tag, "_nstrobe"}, 32'(n_str), 32'd2);
    check({tag, "_cmd"}, 32'(s0), 32'(v.e_s0));
    check({tag, "_data"}, 32'(s1), 32'(v.e_s1));
    check({tag, "_rsp"}, 32'(ar), 32'(er));
    check({tag, "_div_strobe"}, 32'(div_s), 32'(v.e_div));
    check({tag, "_div_rsp"}, 32'(div_r), 32'(v.e_div));
    check({tag, "_busy_rsp"}, 32'(busy_r), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lo, ns, cyc, w, r, nwr, nrd, nrsp, seen;
    logic [8:0] s0, s1;
    logic [10:0] rsp;
    logic [7:0] ds, dr;
    logic br, acc_seen;
    logic [3:0] seq;

    rst = 1'b1; cfg_sclk_div = 8'd4;
    req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = '0; req1_wdata = '0;
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_strobes", 32'({wr_en, rd_en, busy, req0_ready, req1_ready}), 32'd0);
    check("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_rdata, rsp1_rdata}), 32'd0);
    check("rst_tx", 32'(tx_wr_data), 32'd0);
    check("rst_div", 32'(sclk_divider), 32'd4);

    vecs[0] = '{0, 1'b0, 7'h12, 8'hA5, 8'd4,  8'd4,  0, 9'h012, 9'h0A5, 8'h00, 8'd4,  5};
    vecs[1] = '{1, 1'b1, 7'h05, 8'h00, 8'd4,  8'd4,  0, 9'h085, 9'h100, 8'h5A, 8'd4,  5};
    vecs[2] = '{0, 1'b0, 7'h7F, 8'h3C, 8'd4,  8'd10, 2, 9'h07F, 9'h03C, 8'h00, 8'd4,  9};
    vecs[3] = '{1, 1'b1, 7'h40, 8'h77, 8'd10, 8'd10, 1, 9'h0C0, 9'h100, 8'h1F, 8'd10, 7};
    vecs[4] = '{1, 1'b0, 7'h00, 8'hFF, 8'hFF, 8'h01, 3, 9'h000, 9'h0FF, 8'h00, 8'hFF, 11};
    vecs[5] = '{0, 1'b1, 7'h7E, 8'h11, 8'd2,  8'd2,  0, 9'h0FE, 9'h100, 8'h21, 8'd2,  5};

    for (int i = 0; i < 6; i++) begin
      lat_cur = vecs[i].lat;
      run_xfer(vecs[i].idx, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].div_in, vecs[i].div_mid,
               lo, ns, s0, s1, rsp, ds, dr, br);
      check_xfer($sformatf("vec%0d", i), vecs[i], lo, ns, s0, s1, rsp, ds, dr, br);
    end

    // timeout: command write never finishes; a stray rd_finish is ignored
    mute_wr = 1'b1; cfg_sclk_div = 8'd4;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 7'h33; req0_wdata = 8'h44;
    cyc = 0; w = -1; r = -1; nwr = 0; nrd = 0; rsp = '0;
    while (r < 0 && cyc < 100) begin
      @(negedge clk);
      acc_seen = req0_ready;
      if (wr_en) begin nwr++; if (w < 0) w = cyc; end
      if (rd_en) nrd++;
      if (rsp0_valid || rsp1_valid) begin
        r = cyc; rsp = {rsp1_valid, rsp0_valid, rsp0_rdata | rsp1_rdata, rsp0_err | rsp1_err};
      end
      @(posedge clk); #1;
      if (acc_seen) req0_valid = 1'b0;
      rd_finish = (w >= 0 && cyc == w + 3);
      cyc++;
    end
    rd_finish = 1'b0; req0_valid = 1'b0; mute_wr = 1'b0;
    check("timeout_latency", 32'((r >= 0 && w >= 0) ? r - w : -1), 32'd17);
    check("timeout_wr_count", 32'(nwr), 32'd1);
    check("timeout_rd_count", 32'(nrd), 32'd0);
    check("timeout_rsp", 32'(rsp), 32'({1'b0, 1'b1, 8'h00, 1'b1}));

    // reset while waiting for the read data
    mute_rd = 1'b1; cfg_sclk_div = 8'd9;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 7'h22; req1_wdata = 8'h00;
    cyc = 0; seen = 0;
    while (seen == 0 && cyc < 50) begin
      @(negedge clk);
      acc_seen = req1_ready;
      if (rd_en) seen = 1;
      @(posedge clk); #1;
      if (acc_seen) req1_valid = 1'b0;
      cyc++;
    end
    req1_valid = 1'b0;
    check("rstmid_rd_seen", 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    check("rstmid_div_before", 32'(sclk_divider), 32'd9);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_strobes", 32'({wr_en, rd_en, busy, req0_ready, req1_ready}), 32'd0);
    check("rstmid_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 32'd0);
    check("rstmid_tx", 32'(tx_wr_data), 32'd0);
    check("rstmid_div", 32'(sclk_divider), 32'd4);
    mute_rd = 1'b0;
    nrsp = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) nrsp++;
    end
    check("rstmid_no_rsp", 32'(nrsp), 32'd0);
    lat_cur = 1;
    run_xfer(1, 1'b1, 7'h22, 8'h00, 8'd6, 8'd6, lo, ns, s0, s1, rsp, ds, dr, br);
    check_xfer("rstmid_fresh", '{1, 1'b1, 7'h22, 8'h00, 8'd6, 8'd6, 1, 9'h0A2, 9'h100, 8'h7D, 8'd6, 7},
               lo, ns, s0, s1, rsp, ds, dr, br);

    // contention: both requesters hold valid for four transactions
    do_reset();
    last_srv = 1; exp_q.delete(); rsp_q.delete(); gnt_log.delete();
    rand_lat = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      src0_q.push_back(rand_req());
      src1_q.push_back(rand_req());
    end
    run_queues(0, 1'b0, 400);
    check("contention_count", 32'(gnt_log.size()), 32'd4);
    seq = '1;
    for (int i = 0; i < 4; i++) if (i < gnt_log.size()) seq[3 - i] = gnt_log[i][0];
    check("contention_order", 32'(seq), 32'b0101);

    // randomized traffic with random latency, gaps and divider changes
    gnt_log.delete();
    for (int i = 0; i < 30; i++) begin
      src0_q.push_back(rand_req());
      src1_q.push_back(rand_req());
    end
    run_queues(40, 1'b1, 4000);
    check("random_grants", 32'(gnt_log.size()), 32'd60);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
